// File: rtl/stream_checker_if.sv
// Signal bundle between a stimulus/response driver and stream_checker.
// First-error capture signals exist only when STREAM_CHECKER_FIRST_ERR_EN is defined.
interface stream_checker_if #(
  parameter int CHANNELS      = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ERR_CNT_WIDTH = 16
);
  logic                              start;
  logic                              stop;
  logic                              exp_valid;
  logic [CHANNELS*DATA_WIDTH-1:0]    exp_data;
  logic                              act_valid;
  logic [CHANNELS*DATA_WIDTH-1:0]    act_data;
  logic [CHANNELS-1:0]               mismatch;
  logic [CHANNELS*ERR_CNT_WIDTH-1:0] err_count;
  logic [ERR_CNT_WIDTH-1:0]          check_count;
  logic                              test_passed;
  logic                              busy;
  logic                              done;

`ifdef STREAM_CHECKER_FIRST_ERR_EN
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                     first_err_valid;
  logic [CHAN_W-1:0]        first_err_chan;
  logic [ERR_CNT_WIDTH-1:0] first_err_idx;
  logic [DATA_WIDTH-1:0]    first_err_exp;
  logic [DATA_WIDTH-1:0]    first_err_act;

  modport master (
    output start, stop, exp_valid, exp_data, act_valid, act_data,
    input  mismatch, err_count, check_count, test_passed, busy, done,
    input  first_err_valid, first_err_chan, first_err_idx, first_err_exp, first_err_act
  );
  modport slave (
    input  start, stop, exp_valid, exp_data, act_valid, act_data,
    output mismatch, err_count, check_count, test_passed, busy, done,
    output first_err_valid, first_err_chan, first_err_idx, first_err_exp, first_err_act
  );
`else
  modport master (
    output start, stop, exp_valid, exp_data, act_valid, act_data,
    input  mismatch, err_count, check_count, test_passed, busy, done
  );
  modport slave (
    input  start, stop, exp_valid, exp_data, act_valid, act_data,
    output mismatch, err_count, check_count, test_passed, busy, done
  );
`endif
endinterface

// File: rtl/stream_checker.sv
// Multi-channel latency-aligned output checker with tolerance, saturating stats and sticky pass.
// Optional first-error capture is built when STREAM_CHECKER_FIRST_ERR_EN is defined.
module stream_checker #(
  parameter int CHANNELS      = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int LATENCY       = 2,
  parameter int TOLERANCE     = 0,
  parameter int SIGNED_DATA   = 0,
  parameter int ERR_CNT_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  stream_checker_if.slave bus
);
  localparam int VEC_W     = CHANNELS * DATA_WIDTH;
  localparam int DW1       = DATA_WIDTH + 1;
  localparam int FLUSH_LEN = (LATENCY == 0) ? 1 : LATENCY;
  localparam int FC_W      = $clog2(FLUSH_LEN + 1);
  localparam logic [DATA_WIDTH:0] TOL_W = DW1'(TOLERANCE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [FC_W-1:0]   r_flush_cnt;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_cmp_valid;
  logic [VEC_W-1:0]  w_cmp_exp;
  logic [CHANNELS-1:0] w_ch_err;

  // start only restarts a finished or idle checker; in RUN/FLUSH it is ignored.
  assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_accept   = (r_state == S_RUN) && bus.exp_valid;

  // NOTE: sequential blocks use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 1'b1 : '0;
    end
  end

  // NOTE: w_next gets its default first so this block cannot infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (bus.stop) w_next = S_FLUSH;
      S_FLUSH: if (r_flush_cnt == FC_W'(FLUSH_LEN - 1)) w_next = S_DONE;
      S_DONE:  if (bus.start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_RUN, S_FLUSH: bus.busy = 1'b1;
      S_DONE:         bus.done = 1'b1;
      default:        ;
    endcase
  end

  generate
    if (LATENCY == 0) begin : g_direct
      assign w_cmp_valid = w_accept;
      assign w_cmp_exp   = bus.exp_data;
    end else begin : g_dline
      logic [LATENCY-1:0] r_dl_valid;
      logic [VEC_W-1:0]   r_dl_data [LATENCY];

      always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
          r_dl_valid <= '0;
        end else begin
          r_dl_valid[0] <= w_accept;
          for (int i = 1; i < LATENCY; i++) r_dl_valid[i] <= r_dl_valid[i-1];
        end
      end

      // NOTE: payload stages are deliberately not reset; the valid bits alone gate comparison.
      always_ff @(posedge clk) begin
        r_dl_data[0] <= bus.exp_data;
        for (int i = 1; i < LATENCY; i++) r_dl_data[i] <= r_dl_data[i-1];
      end

      assign w_cmp_valid = r_dl_valid[LATENCY-1];
      assign w_cmp_exp   = r_dl_data[LATENCY-1];
    end
  endgenerate

  // One extra bit keeps the difference exact: 0x0000 vs 0xFFFF never wraps.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DATA_WIDTH-1:0]   w_e;
    logic [DATA_WIDTH-1:0]   w_a;
    logic signed [DATA_WIDTH:0] w_ex;
    logic signed [DATA_WIDTH:0] w_ax;
    logic signed [DATA_WIDTH:0] w_diff;
    logic [DATA_WIDTH:0]     w_mag;

    assign w_e    = w_cmp_exp[c*DATA_WIDTH +: DATA_WIDTH];
    assign w_a    = bus.act_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign w_ex   = (SIGNED_DATA != 0) ? {w_e[DATA_WIDTH-1], w_e} : {1'b0, w_e};
    assign w_ax   = (SIGNED_DATA != 0) ? {w_a[DATA_WIDTH-1], w_a} : {1'b0, w_a};
    assign w_diff = w_ax - w_ex;
    assign w_mag  = w_diff[DATA_WIDTH] ? DW1'(-w_diff) : DW1'(w_diff);
    assign w_ch_err[c] = !bus.act_valid || (w_mag > TOL_W);
  end

  logic [CHANNELS-1:0]      r_mismatch;
  logic [ERR_CNT_WIDTH-1:0] r_err [CHANNELS];
  logic [ERR_CNT_WIDTH-1:0] r_check;
  logic                     r_passed;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_mismatch <= '0;
      r_check    <= '0;
      r_passed   <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) r_err[c] <= '0;
    end else begin
      r_mismatch <= w_cmp_valid ? w_ch_err : '0;
      if (w_cmp_valid) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (w_ch_err[c] && r_err[c] != '1) r_err[c] <= r_err[c] + 1'b1;
        end
        if (r_check != '1) r_check <= r_check + 1'b1;
        if (|w_ch_err) r_passed <= 1'b0;
      end
    end
  end

  assign bus.mismatch    = r_mismatch;
  assign bus.check_count = r_check;
  assign bus.test_passed = r_passed;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_err_out
    assign bus.err_count[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = r_err[c];
  end

`ifdef STREAM_CHECKER_FIRST_ERR_EN
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHAN_W-1:0]        w_low;
  logic                     r_fe_valid;
  logic [CHAN_W-1:0]        r_fe_chan;
  logic [ERR_CNT_WIDTH-1:0] r_fe_idx;
  logic [DATA_WIDTH-1:0]    r_fe_exp;
  logic [DATA_WIDTH-1:0]    r_fe_act;

  always_comb begin
    w_low = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) if (w_ch_err[c]) w_low = CHAN_W'(c);
  end

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_fe_valid <= 1'b0;
      r_fe_chan  <= '0;
      r_fe_idx   <= '0;
      r_fe_exp   <= '0;
      r_fe_act   <= '0;
    end else if (w_cmp_valid && |w_ch_err && !r_fe_valid) begin
      r_fe_valid <= 1'b1;
      r_fe_chan  <= w_low;
      r_fe_idx   <= r_check;
      r_fe_exp   <= w_cmp_exp[w_low*DATA_WIDTH +: DATA_WIDTH];
      r_fe_act   <= bus.act_data[w_low*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.first_err_valid = r_fe_valid;
  assign bus.first_err_chan  = r_fe_chan;
  assign bus.first_err_idx   = r_fe_idx;
  assign bus.first_err_exp   = r_fe_exp;
  assign bus.first_err_act   = r_fe_act;
`endif
endmodule
